// File: rtl/fifo_audio_pkg.sv
// Shared types and sizing helpers for the multi-channel audio sample FIFO.
package fifo_audio_pkg;

  localparam int UnderrunW   = 16;
  localparam int DefChannels = 2;
  localparam int DefSampleW  = 24;

  // Frame type for the default stereo 24-bit configuration.
  typedef logic [DefChannels*DefSampleW-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE_NO_DATA,
    STREAM,
    REPEAT
  } repeat_state_e;

  function automatic int frame_width(input int channels, input int sample_width);
    return channels * sample_width;
  endfunction

  function automatic int cnt_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: synchronous write, synchronous read returning pre-write contents.
module ram_1r1w_sync #(
  parameter int width_p      = 48,
  parameter int depth_log2_p = 4
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [depth_log2_p-1:0] waddr_i,
  input  logic [width_p-1:0]      wdata_i,
  input  logic [depth_log2_p-1:0] raddr_i,
  output logic [width_p-1:0]      rdata_o
);

  logic [width_p-1:0] mem_q [2**depth_log2_p];
  logic [width_p-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_1r1w_audio.sv
// Multi-channel audio frame FIFO: sync-read RAM behind a first-word output register.
// Optional underrun sample-repeat enabled by macro FIFO_1R1W_AUDIO_UNDERRUN_REPEAT_EN.
module fifo_1r1w_audio
  import fifo_audio_pkg::*;
#(
  parameter int channels_p     = 2,
  parameter int sample_width_p = 24,
  parameter int depth_log2_p   = 4,
  parameter int almost_full_p  = 12,
  parameter int almost_empty_p = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [channels_p*sample_width_p-1:0]   data_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic [channels_p*sample_width_p-1:0]   data_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic [depth_log2_p:0]                  count_o,
  output logic                                   almost_full_o,
  output logic                                   almost_empty_o,
  output logic [UnderrunW-1:0]                   underrun_count_o
);

  localparam int FrameW = frame_width(channels_p, sample_width_p);
  localparam int CntW   = cnt_width(depth_log2_p);
  localparam int PtrW   = ptr_width(depth_log2_p);
  localparam int AddrW  = depth_log2_p;

  localparam logic [CntW-1:0] Capacity = CntW'(2**depth_log2_p);
  localparam logic [CntW-1:0] AfullTh  = CntW'(almost_full_p);
  localparam logic [CntW-1:0] AemptyTh = CntW'(almost_empty_p);

  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FrameW-1:0] dout_q, dout_d;
  logic [FrameW-1:0] fwd_data_q, ram_rdata, head_ram;
  logic              fwd_q, fwd_d;
  logic              live_q;
  logic              push, pop_real, has_ram, ram_we, rd_adv;

  // Head frame lives in dout_q; frames 2..count live in the RAM at rd_ptr..wr_ptr-1.
  always_comb begin
    push     = valid_i & ready_o;
    pop_real = ready_i & (count_q != '0);
    has_ram  = count_q > CntW'(1);
    ram_we   = push & ~((count_q == '0) | ((count_q == CntW'(1)) & pop_real));
    rd_adv   = pop_real & has_ram;
    wr_ptr_d = wr_ptr_q + PtrW'(ram_we);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_adv);
    count_d  = count_q + CntW'(push) - CntW'(pop_real);
    fwd_d    = ram_we & (wr_ptr_q[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);
    head_ram = fwd_q ? fwd_data_q : ram_rdata;
    dout_d   = dout_q;
    if (pop_real && has_ram) begin
      dout_d = head_ram;
    end else if ((count_q == '0 || pop_real) && push) begin
      dout_d = data_i;
    end
  end

  // The RAM continuously reads the next head address so a pop refills dout_q with no bubble;
  // a write landing on that address in the same cycle is forwarded from fwd_data_q.
  ram_1r1w_sync #(
    .width_p      (FrameW),
    .depth_log2_p (AddrW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AddrW-1:0]),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_d[AddrW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      fwd_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      fwd_q    <= fwd_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    fwd_data_q <= data_i;
  end

  assign ready_o        = live_q & (count_q != Capacity);
  assign data_o         = dout_q;
  assign count_o        = count_q;
  assign almost_full_o  = count_q >= AfullTh;
  assign almost_empty_o = count_q <= AemptyTh;

`ifdef FIFO_1R1W_AUDIO_UNDERRUN_REPEAT_EN
  function automatic logic [UnderrunW-1:0] sat_inc(input logic [UnderrunW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  repeat_state_e       state_q, state_d;
  logic [UnderrunW-1:0] und_q, und_d;
  logic                rep_active;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE_NO_DATA;
      und_q   <= '0;
    end else begin
      state_q <= state_d;
      und_q   <= und_d;
    end
  end

  always_comb begin
    state_d = state_q;
    und_d   = und_q;
    case (state_q)
      IDLE_NO_DATA: if (pop_real) state_d = (count_d == '0) ? REPEAT : STREAM;
      STREAM:       if (count_d == '0) state_d = REPEAT;
      REPEAT:       if (count_d != '0) state_d = STREAM;
      default:      state_d = IDLE_NO_DATA;
    endcase
    if (rep_active && ready_i) begin
      und_d = sat_inc(und_q);
    end
  end

  always_comb begin
    rep_active       = (state_q == REPEAT);
    valid_o          = (count_q != '0) | rep_active;
    underrun_count_o = und_q;
  end
`else
  assign valid_o          = (count_q != '0);
  assign underrun_count_o = '0;
`endif

endmodule
